// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
//   state_t       : arbiter FSM states (IDLE, BUSY)
//   NUM_REQ       : number of requesters
//   IDX_W         : width of a requester index
//   LAST_RST      : reset value of the round-robin pointer (index 0 wins first)
//   idx_to_onehot : requester index -> one-hot grant vector
package mux4_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam logic [IDX_W-1:0] LAST_RST = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_4.sv
// 4:1 data multiplexer, purely combinational.
//   sel1, sel2 : select MSB / LSB (00/01/10/11 -> in_0/in_1/in_2/in_3)
//   in_0..in_3 : data inputs, DATA_W bits each
//   mux_out    : selected data
module mux_4 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              sel1,
  input  logic              sel2,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  output logic [DATA_W-1:0] mux_out
);

  always_comb begin
    mux_out = in_0;
    case ({sel1, sel2})
      2'b00:   mux_out = in_0;
      2'b01:   mux_out = in_1;
      2'b10:   mux_out = in_2;
      default: mux_out = in_3;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter over four requesters driving a 4:1 data mux.
// A grant is held for as long as the owner keeps its request high; on release
// the next requester (searched from last+1) is granted on the same edge.
// Optional build macro MUX4_ARB_TIMEOUT_EN bounds each tenure to HOLD_MAX
// cycles when another requester is waiting.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : request vector, bit i = requester i
//   in_0..in_3 : requester data
//   gnt        : registered one-hot grant (or zero)
//   sel1, sel2 : registered mux select (owner index, held in IDLE)
//   mux_out    : combinational mux output selected by sel1/sel2
//   valid      : registered, high while gnt is non-zero
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  in_0,
  input  logic [DATA_W-1:0]  in_1,
  input  logic [DATA_W-1:0]  in_2,
  input  logic [DATA_W-1:0]  in_3,
  output logic [NUM_REQ-1:0] gnt,
  output logic               sel1,
  output logic               sel2,
  output logic [DATA_W-1:0]  mux_out,
  output logic               valid
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [IDX_W-1:0]   sel_d;
  logic               valid_d;
  logic [NUM_REQ-1:0] cand;
  logic [IDX_W:0]     pick;
  logic               grant_now;

  // Round-robin search: candidates last+1, last+2, last+3, last; returns {found, idx}.
  // Iterating from the farthest candidate lets the nearest one overwrite the result.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = last + IDX_W'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // In BUSY the owner is excluded so a forced switch never re-picks it.
  assign cand = (state_q == BUSY) ? (req & ~idx_to_onehot(last_q)) : req;
  assign pick = rr_pick(cand, last_q);

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             hold_expired;

  assign hold_expired = (hold_q == CNT_MAX);

  // Tenure counter: clears on each grant, saturates while uncontested.
  always_comb begin
    hold_d = hold_q;
    if (grant_now) begin
      hold_d = '0;
    end else if (state_q == BUSY && !hold_expired) begin
      hold_d = hold_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt;
    sel_d     = {sel1, sel2};
    grant_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick[IDX_W]) grant_now = 1'b1;
      end
      BUSY: begin
        if (!req[last_q]) begin
          if (pick[IDX_W]) begin
            grant_now = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
`ifdef MUX4_ARB_TIMEOUT_EN
        else if (hold_expired && pick[IDX_W]) begin
          grant_now = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    if (grant_now) begin
      state_d = BUSY;
      last_d  = pick[IDX_W-1:0];
      gnt_d   = idx_to_onehot(pick[IDX_W-1:0]);
      sel_d   = pick[IDX_W-1:0];
    end

    valid_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      gnt     <= '0;
      sel1    <= 1'b0;
      sel2    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt     <= gnt_d;
      sel1    <= sel_d[1];
      sel2    <= sel_d[0];
      valid   <= valid_d;
    end
  end

  mux_4 #(
    .DATA_W (DATA_W)
  ) u_mux_4 (
    .sel1    (sel1),
    .sel2    (sel2),
    .in_0    (in_0),
    .in_1    (in_1),
    .in_2    (in_2),
    .in_3    (in_3),
    .mux_out (mux_out)
  );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed request sequences push the
// expected grant/select for the following cycle; a negedge monitor compares
// every cycle that has an expectation and flags any unexpected valid output.
module tb_mux4_rr_arbiter;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = 4'b0000;
  logic [DW-1:0] in_0 = 8'hA0;
  logic [DW-1:0] in_1 = 8'hB1;
  logic [DW-1:0] in_2 = 8'hC2;
  logic [DW-1:0] in_3 = 8'hD3;
  logic [3:0]    gnt;
  logic          sel1, sel2;
  logic [DW-1:0] mux_out;
  logic          valid;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    int unsigned cyc;
    logic        vld;
    logic [3:0]  gnt;
    logic [1:0]  sel;
  } exp_t;

  exp_t sb[$];

  mux4_rr_arbiter #(
    .DATA_W   (DW),
    .HOLD_MAX (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .in_0    (in_0),
    .in_1    (in_1),
    .in_2    (in_2),
    .in_3    (in_3),
    .gnt     (gnt),
    .sel1    (sel1),
    .sel2    (sel2),
    .mux_out (mux_out),
    .valid   (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] data_of(input logic [1:0] s);
    case (s)
      2'd0:    return in_0;
      2'd1:    return in_1;
      2'd2:    return in_2;
      default: return in_3;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive req for the next sampled edge and queue the expected result.
  task automatic step(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s);
    exp_t e;
    @(negedge clk);
    req   = r;
    e.cyc = cyc + 1;
    e.vld = (g != 4'b0000);
    e.gnt = g;
    e.sel = s;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare outputs against the entry due this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_expectation", 32'(e.cyc), 32'(cyc));
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("valid",   32'(valid),        32'(e.vld));
      chk("gnt",     32'(gnt),          32'(e.gnt));
      chk("sel",     32'({sel1, sel2}), 32'(e.sel));
      chk("mux_out", 32'(mux_out),      32'(data_of(e.sel)));
    end else if (valid) begin
      chk("unexpected_valid", 32'(valid), 32'(0));
    end
  end

  initial begin
    #200000;
    chk("watchdog", 32'(1), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    // Reset values.
    #7;
    chk("rst_gnt",   32'(gnt),          32'(0));
    chk("rst_valid", 32'(valid),        32'(0));
    chk("rst_sel",   32'({sel1, sel2}), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single requester 0: grant one cycle later, then release to idle.
    step(4'b0001, 4'b0001, 2'd0);
    step(4'b0000, 4'b0000, 2'd0);

    // All request, each drops after its grant: order 0,1,2,3 with no gap.
    do_reset();
    step(4'b1111, 4'b0001, 2'd0);
    step(4'b1110, 4'b0010, 2'd1);
    step(4'b1100, 4'b0100, 2'd2);
    step(4'b1000, 4'b1000, 2'd3);
    step(4'b0000, 4'b0000, 2'd3);

    // last=3 idle; grant 2, release with 1011 -> 3, then 0, then 1, then idle on 01.
    step(4'b0100, 4'b0100, 2'd2);
    step(4'b0100, 4'b0100, 2'd2);
    step(4'b1011, 4'b1000, 2'd3);
    step(4'b0011, 4'b0001, 2'd0);
    step(4'b0010, 4'b0010, 2'd1);
    step(4'b0000, 4'b0000, 2'd1);
    step(4'b0000, 4'b0000, 2'd1);

    // Asynchronous reset mid-tenure with gnt = 0100.
    step(4'b0100, 4'b0100, 2'd2);
    step(4'b0100, 4'b0100, 2'd2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    chk("async_rst_gnt",   32'(gnt),          32'(0));
    chk("async_rst_valid", 32'(valid),        32'(0));
    chk("async_rst_sel",   32'({sel1, sel2}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    step(4'b1111, 4'b0001, 2'd0);
    step(4'b1110, 4'b0010, 2'd1);
    step(4'b0000, 4'b0000, 2'd1);

    // Owner 0 held while 1 competes.
    do_reset();
    step(4'b0001, 4'b0001, 2'd0);
    step(4'b0011, 4'b0001, 2'd0);
    step(4'b0011, 4'b0001, 2'd0);
    step(4'b0011, 4'b0001, 2'd0);
`ifdef MUX4_ARB_TIMEOUT_EN
    step(4'b0011, 4'b0010, 2'd1);
    step(4'b0001, 4'b0001, 2'd0);
`else
    for (int i = 0; i < 12; i++) step(4'b0011, 4'b0001, 2'd0);
    step(4'b0001, 4'b0001, 2'd0);
`endif
    step(4'b0000, 4'b0000, 2'd0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
